issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 74 +++++++
 tb/tb_issue_scoreboard.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order issue stage with per-register ALU countdown and load-lock scoreboard.
module issue_scoreboard #(
  parameter int ALU_LAT = 2,
  parameter int MAX_LOADS = 4,
  parameter int PAY_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic             dec_illegal,
  input  logic             dec_use_rsj,
  input  logic             dec_use_rsk,
  input  logic             dec_use_rsd,
  input  logic [4:0]       dec_rsj,
  input  logic [4:0]       dec_rsk,
  input  logic [4:0]       dec_rsd,
  input  logic [1:0]       dec_rsd_lockout,
  input  logic [PAY_W-1:0] dec_payload,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [PAY_W-1:0] iss_payload,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rsd,
  input  logic             flush,
  output logic             trap,
  output logic [31:0]      busy_vec
);
  localparam int CW = $clog2(MAX_LOADS + 1);
  typedef enum logic {RUN, TRAP} state_t;
  state_t state, state_nx;
  logic [1:0] alu_cnt [32];
  logic [31:0] load_bits;
  logic [CW-1:0] load_cnt;
  logic hazard, take, legal, set_alu, set_ld, clr_ld, inc, dec;
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < 32; i++) busy_vec[i] = alu_cnt[i] != 2'd0 || load_bits[i];
  end
  always_comb begin
    hazard = (dec_use_rsj && busy_vec[dec_rsj]) || (dec_use_rsk && busy_vec[dec_rsk]) ||
             (dec_use_rsd && busy_vec[dec_rsd]) ||
             (dec_rsd_lockout[1] && load_cnt == CW'(MAX_LOADS));
    dec_ready = state == RUN && !hazard && (!iss_valid || iss_ready);
    // flush wins over a same-cycle accept: the instruction is dropped entirely
    take = dec_valid && dec_ready && !flush;
    legal = take && !dec_illegal;
    set_alu = legal && dec_use_rsd && dec_rsd != 5'd0 && dec_rsd_lockout == 2'd1;
    set_ld = legal && dec_use_rsd && dec_rsd != 5'd0 && dec_rsd_lockout[1];
    clr_ld = wb_valid && load_bits[wb_rsd];
    inc = set_ld && !load_bits[dec_rsd];
    dec = clr_ld && !(set_ld && dec_rsd == wb_rsd);
    state_nx = flush ? RUN : (take && dec_illegal) ? TRAP : state;
  end
  always_ff @(posedge clk) state <= rst ? RUN : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_payload <= '0;
      trap <= 1'b0;
      load_bits <= '0;
      load_cnt <= '0;
      for (int i = 0; i < 32; i++) alu_cnt[i] <= 2'd0;
    end else begin
      trap <= take && dec_illegal;
      iss_valid <= !flush && (legal || (iss_valid && !iss_ready));
      if (legal) iss_payload <= dec_payload;
      for (int i = 0; i < 32; i++)
        alu_cnt[i] <= (set_alu && dec_rsd == 5'(i)) ? 2'(ALU_LAT) : alu_cnt[i] - {1'b0, |alu_cnt[i]};
      load_bits <= (load_bits & ~({31'b0, clr_ld} << wb_rsd)) | ({31'b0, set_ld} << dec_rsd);
      load_cnt <= load_cnt + CW'(inc) - CW'(dec);
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed vectors with hand-computed expectations for issue_scoreboard.
module tb_issue_scoreboard;
  logic clk = 1'b0, rst = 1'b1;
  logic dec_valid = 0, dec_ready, dec_illegal = 0;
  logic dec_use_rsj = 0, dec_use_rsk = 0, dec_use_rsd = 0;
  logic [4:0] dec_rsj = 0, dec_rsk = 0, dec_rsd = 0;
  logic [1:0] dec_rsd_lockout = 0;
  logic [63:0] dec_payload = 0, iss_payload;
  logic iss_valid, iss_ready = 1, wb_valid = 0, flush = 0, trap;
  logic [4:0] wb_rsd = 0;
  logic [31:0] busy_vec;
  int npass = 0, ntot = 0;
  always #5 clk = ~clk;
  issue_scoreboard #(.ALU_LAT(2), .MAX_LOADS(4), .PAY_W(64)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_illegal(dec_illegal),
    .dec_use_rsj(dec_use_rsj), .dec_use_rsk(dec_use_rsk), .dec_use_rsd(dec_use_rsd),
    .dec_rsj(dec_rsj), .dec_rsk(dec_rsk), .dec_rsd(dec_rsd), .dec_rsd_lockout(dec_rsd_lockout),
    .dec_payload(dec_payload), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
    .wb_valid(wb_valid), .wb_rsd(wb_rsd), .flush(flush), .trap(trap), .busy_vec(busy_vec)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic il, input logic uj, input logic uk, input logic ud,
                     input logic [4:0] j, input logic [4:0] k, input logic [4:0] d,
                     input logic [1:0] lo, input logic [63:0] p);
    dec_valid = v; dec_illegal = il; dec_use_rsj = uj; dec_use_rsk = uk; dec_use_rsd = ud;
    dec_rsj = j; dec_rsk = k; dec_rsd = d; dec_rsd_lockout = lo; dec_payload = p;
    #1;
  endtask
  task automatic idle;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic load(input logic [4:0] r, input logic [63:0] p);
    drv(1, 0, 0, 0, 1, 0, 0, r, 2'd2, p);
  endtask
  task automatic wb(input logic [4:0] r);
    wb_valid = 1; wb_rsd = r;
    tick;
    wb_valid = 0;
    #1;
  endtask
  initial begin
    tick; tick;
    rst = 0;
    tick;
    check("rst_ready", dec_ready, 1);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_trap", trap, 0);
    check("rst_busy", busy_vec, 0);
    check("rst_payload", iss_payload, 0);
    // ALU RAW on x5
    drv(1, 0, 0, 0, 1, 0, 0, 5, 2'd1, 64'hA);
    check("alu_first_ready", dec_ready, 1);
    tick;
    drv(1, 0, 1, 0, 0, 5, 0, 0, 2'd0, 64'hB);
    check("alu_iss_valid", iss_valid, 1);
    check("alu_payload", iss_payload, 64'hA);
    check("alu_busy_c1", busy_vec[5], 1);
    check("alu_stall_c1", dec_ready, 0);
    tick;
    check("alu_busy_c2", busy_vec[5], 1);
    check("alu_stall_c2", dec_ready, 0);
    check("alu_drained", iss_valid, 0);
    tick;
    check("alu_busy_c3", busy_vec[5], 0);
    check("alu_ready_c3", dec_ready, 1);
    tick;
    idle;
    check("alu_second_payload", iss_payload, 64'hB);
    // load RAW on x7
    load(7, 64'hC);
    tick;
    drv(1, 0, 1, 0, 0, 7, 0, 0, 2'd0, 64'hD);
    for (int i = 0; i < 3; i++) begin
      check("ld_stall", dec_ready, 0);
      check("ld_busy", busy_vec[7], 1);
      tick;
    end
    wb_valid = 1; wb_rsd = 7; #1;
    check("ld_no_bypass", dec_ready, 0);
    tick;
    wb_valid = 0; #1;
    check("ld_cleared", busy_vec[7], 0);
    check("ld_ready", dec_ready, 1);
    tick;
    idle;
    check("ld_payload", iss_payload, 64'hD);
    // load limit
    for (int r = 1; r <= 4; r++) begin
      load(5'(r), 64'(r));
      check("lim_fill_ready", dec_ready, 1);
      tick;
    end
    load(6, 64'h6);
    check("lim_busy", busy_vec, 32'h1E);
    check("lim_stall", dec_ready, 0);
    wb_valid = 1; wb_rsd = 2; #1;
    check("lim_wb_no_bypass", dec_ready, 0);
    tick;
    wb_valid = 0; #1;
    check("lim_ready_after_wb", dec_ready, 1);
    tick;
    load(8, 64'h8);
    check("lim_count_4", dec_ready, 0);
    check("lim_busy2", busy_vec, 32'h5A);
    idle;
    wb(1); wb(3); wb(4); wb(6);
    check("lim_clear", busy_vec, 0);
    // stray writebacks must not underflow the count
    wb(0); wb(15);
    check("stray_busy", busy_vec, 0);
    // collision on x9
    load(9, 64'h9);
    tick;
    load(9, 64'h19);
    wb_valid = 1; wb_rsd = 9; #1;
    check("col_hazard", dec_ready, 0);
    tick;
    wb_valid = 0; #1;
    check("col_ready", dec_ready, 1);
    tick;
    check("col_busy9", busy_vec[9], 1);
    for (int r = 10; r <= 12; r++) begin
      load(5'(r), 64'(r));
      check("col_count_ready", dec_ready, 1);
      tick;
    end
    load(13, 64'hD);
    check("col_count_full", dec_ready, 0);
    idle;
    wb(9); wb(10); wb(11); wb(12);
    check("col_clear", busy_vec, 0);
    // x0 and backpressure
    iss_ready = 0;
    drv(1, 0, 0, 0, 1, 0, 0, 0, 2'd1, 64'hD0);
    check("x0_ready", dec_ready, 1);
    tick;
    drv(1, 0, 1, 1, 0, 0, 0, 0, 2'd0, 64'hE0);
    check("x0_busy", busy_vec, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", dec_ready, 0);
      check("bp_valid", iss_valid, 1);
      check("bp_payload", iss_payload, 64'hD0);
      tick;
    end
    iss_ready = 1; #1;
    check("bp_release", dec_ready, 1);
    tick;
    check("bp_next_payload", iss_payload, 64'hE0);
    check("bp_next_valid", iss_valid, 1);
    // illegal instruction
    drv(1, 1, 0, 0, 1, 0, 0, 3, 2'd2, 64'hF0);
    check("ill_ready", dec_ready, 1);
    tick;
    idle;
    check("ill_trap", trap, 1);
    check("ill_no_issue", iss_valid, 0);
    check("ill_no_lock", busy_vec, 0);
    check("ill_blocked", dec_ready, 0);
    tick;
    check("ill_trap_pulse", trap, 0);
    check("ill_still_blocked", dec_ready, 0);
    flush = 1;
    tick;
    flush = 0; #1;
    check("ill_flush_ready", dec_ready, 1);
    // flush beats accept, and discards a held issue
    iss_ready = 0;
    drv(1, 0, 0, 0, 1, 0, 0, 3, 2'd1, 64'h60);
    flush = 1;
    tick;
    flush = 0;
    idle;
    check("fl_drop_valid", iss_valid, 0);
    check("fl_drop_lock", busy_vec[3], 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 64'h70);
    tick;
    idle;
    check("fl_held", iss_valid, 1);
    flush = 1;
    tick;
    flush = 0; #1;
    check("fl_cleared", iss_valid, 0);
    iss_ready = 1;
    // reset mid-operation
    load(5, 64'h55);
    tick;
    idle;
    check("mr_locked", busy_vec[5], 1);
    rst = 1;
    tick;
    rst = 0; #1;
    check("mr_busy", busy_vec, 0);
    check("mr_valid", iss_valid, 0);
    check("mr_ready", dec_ready, 1);
    wb(5);
    check("mr_wb_ignored", busy_vec, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
